// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer memory.
// State encoding, pprot bit positions and default bus widths.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    localparam int PPROT_PRIV = 0;
    localparam int PPROT_NSEC = 1;
    localparam int PPROT_INSN = 2;

    typedef enum logic [1:0] {
        APB_IDLE  = 2'd0,
        APB_WAIT  = 2'd1,
        APB_READY = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_completer_mem_if.sv
// APB4 bus bundle between the bridge (master) and a completer (slave).
interface apb_completer_mem_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [2:0]            pprot;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr,
        output pprot, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr,
        input  pprot, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_regfile.sv
// Word array with async clear, byte-strobed write port and a
// registered read port whose output doubles as the bus read data.
module apb_regfile #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int SW     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [SW-1:0]     i_wstrb,
    input  logic              i_re,
    input  logic              i_rclr,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                for (int b = 0; b < SW; b++) begin
                    if (i_wstrb[b]) begin
                        r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
            // Load wins over clear; the two never coincide in practice.
            if (i_re) begin
                r_rdata <= r_mem[i_ridx];
            end else if (i_rclr) begin
                r_rdata <= '0;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer backed by a word store: wait states, byte strobes,
// range/alignment/protection errors and a saturating error counter.
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                DEPTH       = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 0,
    parameter int                PROT_START  = DEPTH / 2
) (
    input  logic                      pclk,
    input  logic                      preset,
    apb_completer_mem_if.slave        bus,
    output logic [7:0]                err_cnt
);

    localparam int                SW    = DATA_W / 8;
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * SW);

    apb_state_e        r_state;
    logic              r_ready;
    logic              r_slverr;
    logic              r_write;
    logic              r_err;
    logic [3:0]        r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [SW-1:0]     r_wstrb;
    logic [7:0]        r_err_cnt;

    logic              w_setup;
    logic              w_access;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_prot_hit;
    logic              w_err;
    logic              w_fast;
    logic              w_wait_done;
    logic              w_we;
    logic              w_re;
    logic              w_rclr;
    logic [IDX_W-1:0]  w_ridx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    assign w_setup  = bus.psel & ~bus.penable;
    assign w_access = bus.psel & bus.penable;

    // Addresses below the base wrap to a huge offset and fail the span test.
    assign w_off = bus.paddr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];

    assign w_prot_hit = bus.pwrite
                      & (int'(w_idx) >= PROT_START)
                      & (bus.pprot[PPROT_NSEC]
                         | ~bus.pprot[PPROT_PRIV]);

    assign w_err = (w_off >= SPAN)
                 | (bus.paddr[1:0] != 2'b00)
                 | w_prot_hit;

    assign w_unused = ^{w_off[1:0], bus.pprot[PPROT_INSN]};

    assign w_fast = (r_state == APB_IDLE) & w_setup
                  & (WAIT_CYCLES == 0);
    assign w_wait_done = (r_state == APB_WAIT) & w_access
                       & (r_cnt == 4'd1);

    // Read data is fetched on the edge that enters READY.
    assign w_re = (w_fast & ~bus.pwrite & ~w_err)
                | (w_wait_done & ~r_write & ~r_err);
    assign w_ridx = (r_state == APB_IDLE) ? w_idx : r_idx;
    assign w_rclr = (r_state == APB_READY)
                  & (~bus.psel | bus.penable);
    assign w_we = (r_state == APB_READY) & w_access
                & r_write & ~r_err;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= APB_IDLE;
            r_ready   <= 1'b0;
            r_slverr  <= 1'b0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_err_cnt <= '0;
        end else begin
            unique case (r_state)
                APB_IDLE: begin
                    r_ready  <= 1'b0;
                    r_slverr <= 1'b0;
                    if (w_setup) begin
                        r_write <= bus.pwrite;
                        r_err   <= w_err;
                        r_idx   <= w_idx;
                        r_wdata <= bus.pwdata;
                        r_wstrb <= bus.pstrb;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            r_state  <= APB_READY;
                            r_ready  <= 1'b1;
                            r_slverr <= w_err;
                        end else begin
                            r_state <= APB_WAIT;
                        end
                    end
                end
                APB_WAIT: begin
                    if (!bus.psel) begin
                        r_state <= APB_IDLE;
                    end else if (bus.penable) begin
                        if (r_cnt == 4'd1) begin
                            r_state  <= APB_READY;
                            r_ready  <= 1'b1;
                            r_slverr <= r_err;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                APB_READY: begin
                    if (!bus.psel || bus.penable) begin
                        r_state  <= APB_IDLE;
                        r_ready  <= 1'b0;
                        r_slverr <= 1'b0;
                    end
                    if (w_access && r_err && r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= APB_IDLE;
                end
            endcase
        end
    end

    apb_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (pclk),
        .rst     (preset),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_re    (w_re),
        .i_rclr  (w_rclr),
        .i_ridx  (w_ridx),
        .o_rdata (w_rdata)
    );

    assign bus.prdata  = w_rdata;
    assign bus.pready  = r_ready;
    assign bus.pslverr = r_slverr;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: three instances (0/3/2 wait states)
// on shared stimulus, checked against an array-based memory model.
module tb_apb_completer_mem;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          DEP  = 64;
    localparam logic [31:0] SPAN = 32'(DEP * 4);
    localparam int          PROT = DEP / 2;

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        serr  [3];
    logic [7:0]  ec    [3];

    int          waits [3] = '{0, 3, 2};
    logic [31:0] mdl   [3][DEP];
    int          errc  [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : 2;

        apb_completer_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        assign bus.psel    = psel & (sel == g);
        assign bus.penable = penable;
        assign bus.pwrite  = pwrite;
        assign bus.paddr   = paddr;
        assign bus.pprot   = pprot;
        assign bus.pwdata  = pwdata;
        assign bus.pstrb   = pstrb;

        apb_completer_mem #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .DEPTH       (DEP),
            .BASE_ADDR   (BASE),
            .WAIT_CYCLES (WC),
            .PROT_START  (PROT)
        ) u_dut (
            .pclk    (clk),
            .preset  (rst),
            .bus     (bus),
            .err_cnt (ec[g])
        );

        assign rdata[g] = bus.prdata;
        assign rdy[g]   = bus.pready;
        assign serr[g]  = bus.pslverr;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input bit wr, input logic [31:0] a,
                                   input logic [2:0] pr);
        if (a < BASE || a >= BASE + SPAN) return 1'b1;
        if (a % 4 != 0) return 1'b1;
        if (wr && (a - BASE) / 4 >= PROT && !(pr[0] && !pr[1]))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            errc[d] = 0;
            for (int i = 0; i < DEP; i++) mdl[d][i] = '0;
        end
    endtask

    // Starts just after a rising edge; returns just after the commit edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [2:0] pr, input logic [31:0] wd,
                        input logic [3:0] sb);
        bit          e;
        bit          got;
        int          n;
        logic [31:0] exp;
        e = exp_err(wr, a, pr);
        sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = a; pprot = pr; pwdata = wd; pstrb = sb;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = rdy[d];
        end
        chk("latency", n, waits[d] + 1);
        if (got) begin
            chk("pslverr", serr[d], e);
            if (!wr) begin
                exp = e ? 32'h0 : mdl[d][widx(a)];
                chk("prdata", rdata[d], exp);
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        if (got) begin
            if (e) begin
                if (errc[d] < 255) errc[d]++;
            end else if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (sb[b]) mdl[d][widx(a)][8*b +: 8] = wd[8*b +: 8];
            end
        end
        chk("err_cnt", ec[d], errc[d]);
        chk("pready_drop", rdy[d], 0);
        chk("pslverr_drop", serr[d], 0);
        chk("prdata_drop", rdata[d], 0);
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        int          d;
        bit          wr;

        rst = 1'b1; sel = 0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_pready", rdy[i], 0);
            chk("rst_pslverr", serr[i], 0);
            chk("rst_prdata", rdata[i], 0);
            chk("rst_err_cnt", ec[i], 0);
        end
        @(posedge clk); #1;

        // Zero-wait write/read, back to back.
        xfer(0, 1'b1, BASE + 4, 3'b001, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, BASE + 4, 3'b001, 32'h0, 4'h0);
        chk("deadbeef", mdl[0][1], 32'hDEADBEEF);

        // Three wait states, partial strobe merge.
        xfer(1, 1'b1, BASE + 8, 3'b001, 32'hAABBCCDD, 4'hF);
        xfer(1, 1'b1, BASE + 8, 3'b001, 32'h11223344, 4'b0101);
        xfer(1, 1'b0, BASE + 8, 3'b001, 32'h0, 4'h0);
        xfer(1, 1'b1, BASE + 8, 3'b001, 32'hFFFFFFFF, 4'h0);
        xfer(1, 1'b0, BASE + 8, 3'b001, 32'h0, 4'h0);

        // Range and alignment errors.
        xfer(0, 1'b0, BASE + SPAN, 3'b001, 32'h0, 4'h0);
        xfer(0, 1'b0, BASE + 2, 3'b001, 32'h0, 4'h0);
        chk("err_cnt_two", ec[0], 2);

        // Protected region.
        a = BASE + 32'(PROT * 4);
        xfer(0, 1'b1, a, 3'b010, 32'hCAFEF00D, 4'hF);
        xfer(0, 1'b0, a, 3'b010, 32'h0, 4'h0);
        xfer(0, 1'b1, a, 3'b001, 32'hCAFEF00D, 4'hF);
        xfer(0, 1'b0, a, 3'b110, 32'h0, 4'h0);

        // Abort in the first ACCESS cycle.
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = BASE + 12; pprot = 3'b001;
        pwdata = 32'h55555555; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("abort_pready", rdy[2], 0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_idle", rdy[2], 0);
        chk("abort_err_cnt", ec[2], errc[2]);
        @(posedge clk); #1;
        xfer(2, 1'b0, BASE + 12, 3'b001, 32'h0, 4'h0);

        // Randomised traffic across all three instances.
        for (int i = 0; i < 300; i++) begin
            d  = $urandom_range(0, 2);
            wr = 1'($urandom_range(0, 1));
            k  = $urandom_range(0, 9);
            case (k)
                0: a = BASE + SPAN + 32'(4 * $urandom_range(0, 15));
                1: a = BASE - 32'(4 * $urandom_range(1, 4));
                2: a = BASE + 32'(4 * $urandom_range(0, DEP - 1))
                            + 32'($urandom_range(1, 3));
                default: a = BASE + 32'(4 * $urandom_range(0, DEP - 1));
            endcase
            xfer(d, wr, a, 3'($urandom_range(0, 7)), $urandom,
                 4'($urandom_range(0, 15)));
        end

        // Reset during the WAIT state of a read.
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = BASE + 8; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_pready", rdy[1], 0);
        chk("arst_pslverr", serr[1], 0);
        chk("arst_prdata", rdata[1], 0);
        for (int i = 0; i < 3; i++) chk("arst_err_cnt", ec[i], 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            xfer(i, 1'b0, BASE + 4, 3'b001, 32'h0, 4'h0);
            xfer(i, 1'b0, BASE + 8, 3'b001, 32'h0, 4'h0);
            xfer(i, 1'b0, BASE + 32'(PROT * 4), 3'b001, 32'h0, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
